mem_stage_ctrl: RTL and testbench

//  MEM-stage controller between the EXE->MEM pipe register and the MEM->WB pipe register.

---
 rtl/mem_stage_ctrl_pkg.sv | 13 +
 rtl/mem_stage_ctrl_if.sv | 22 ++
 rtl/mem_stage_ctrl_timeout_ctr.sv | 28 ++
 rtl/mem_stage_ctrl.sv | 176 +++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types and widths for the MEM-stage controller.
package mem_stage_pkg;

    localparam int ADDR_W = 32;
    localparam int REG_W  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/ack port: the controller is the master, the memory is the slave.
interface mem_stage_ctrl_if;
    import mem_stage_pkg::*;

    logic [ADDR_W-1:0] mem_addr;
    logic [ADDR_W-1:0] mem_wdata;
    logic              mem_rd;
    logic              mem_wr;
    logic              mem_ack;
    logic [ADDR_W-1:0] mem_rdata;

    modport master (
        output mem_addr, mem_wdata, mem_rd, mem_wr,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_rd, mem_wr,
        output mem_ack, mem_rdata
    );

endinterface

// File: rtl/mem_stage_ctrl_timeout_ctr.sv
// Clear/enable cycle counter for the BUSY wait, flagging the last allowed cycle.
module mem_timeout_ctr #(
    parameter int TERMINAL = 16,
    parameter int WIDTH    = $clog2(TERMINAL) + 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [WIDTH-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == WIDTH'(TERMINAL - 1));

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: runs loads/stores as req/ack transactions, freezing upstream meanwhile.
// Optional build macro: MEM_ALIGN_CHECK_EN (misaligned mem ops abort without touching memory).
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int ADDR_BASE      = 1024,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              WB_EN_IN,
    input  logic              MEM_R_EN_IN,
    input  logic              MEM_W_EN_IN,
    input  logic [ADDR_W-1:0] ALUResIn,
    input  logic [ADDR_W-1:0] STValIn,
    input  logic [REG_W-1:0]  destIn,
    output logic              WB_EN,
    output logic              MEM_R_EN,
    output logic [ADDR_W-1:0] ALURes,
    output logic [ADDR_W-1:0] memData,
    output logic [REG_W-1:0]  dest,
    output logic              freeze,
    output logic              bus_err,
    mem_stage_ctrl_if.master  mem
);

    state_t state_q, state_d;

    logic              mem_op;
    logic              is_load;
    logic              misaligned;
    logic [ADDR_W-1:0] word_addr;

    logic start, skip, ack_done, timeout;
    logic cnt_en, cnt_clr, tc;

    logic              freeze_c, wb_c, bus_err_c;
    logic [ADDR_W-1:0] mem_data_c;

    logic [ADDR_W-1:0] data_q;
    logic              is_load_q;
    logic              abort_q;

    // A load+store combination is resolved as a load.
    assign mem_op    = MEM_R_EN_IN | MEM_W_EN_IN;
    assign is_load   = MEM_R_EN_IN;
    assign word_addr = (ALUResIn - ADDR_W'(ADDR_BASE)) >> 2;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = (ALUResIn[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    mem_timeout_ctr #(
        .TERMINAL (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk    (clk),
        .rst    (rst),
        .clear  (cnt_clr),
        .enable (cnt_en),
        .tc     (tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        start      = 1'b0;
        skip       = 1'b0;
        ack_done   = 1'b0;
        timeout    = 1'b0;
        cnt_en     = 1'b0;
        cnt_clr    = 1'b0;
        freeze_c   = 1'b0;
        wb_c       = WB_EN_IN;
        bus_err_c  = 1'b0;
        mem_data_c = '0;

        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    freeze_c = 1'b1;
                    wb_c     = 1'b0;
                    if (misaligned) begin
                        skip    = 1'b1;
                        state_d = DONE;
                    end else begin
                        start   = 1'b1;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                freeze_c = 1'b1;
                wb_c     = 1'b0;
                cnt_en   = 1'b1;
                // Ack takes priority over a timeout in the same cycle.
                if (mem.mem_ack) begin
                    ack_done = 1'b1;
                    state_d  = DONE;
                end else if (tc) begin
                    timeout = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                cnt_clr = 1'b1;
                state_d = IDLE;
                if (abort_q) begin
                    wb_c      = 1'b0;
                    bus_err_c = 1'b1;
                end else if (is_load_q) begin
                    mem_data_c = data_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            mem.mem_rd    <= 1'b0;
            mem.mem_wr    <= 1'b0;
            data_q        <= '0;
            is_load_q     <= 1'b0;
            abort_q       <= 1'b0;
        end else begin
            if (start) begin
                mem.mem_addr  <= word_addr;
                mem.mem_wdata <= STValIn;
                mem.mem_rd    <= is_load;
                mem.mem_wr    <= ~is_load;
                is_load_q     <= is_load;
                abort_q       <= 1'b0;
            end
            if (skip) begin
                is_load_q <= is_load;
                abort_q   <= 1'b1;
            end
            if (ack_done) begin
                mem.mem_rd <= 1'b0;
                mem.mem_wr <= 1'b0;
                if (is_load_q) begin
                    data_q <= mem.mem_rdata;
                end
            end
            if (timeout) begin
                mem.mem_rd <= 1'b0;
                mem.mem_wr <= 1'b0;
                abort_q    <= 1'b1;
            end
        end
    end

    // While reset is held the still-present upstream mem op must not stall the pipe.
    assign freeze   = freeze_c & ~rst;
    assign bus_err  = bus_err_c & ~rst;
    assign WB_EN    = wb_c;
    assign memData  = mem_data_c;
    assign MEM_R_EN = MEM_R_EN_IN;
    assign ALURes   = ALUResIn;
    assign dest     = destIn;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed cases plus randomized transactions vs a transaction model.
module tb_mem_stage_ctrl;

    localparam int T    = 4;
    localparam int BASE = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_en_in, mem_r_en_in, mem_w_en_in;
    logic [31:0] alu_res_in, st_val_in;
    logic [4:0]  dest_in;
    logic        wb_en, mem_r_en, freeze, bus_err;
    logic [31:0] alu_res, mem_data;
    logic [4:0]  dest;

    int checks   = 0;
    int failures = 0;

    mem_stage_ctrl_if mem_if ();

    mem_stage_ctrl #(
        .ADDR_BASE      (BASE),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .WB_EN_IN    (wb_en_in),
        .MEM_R_EN_IN (mem_r_en_in),
        .MEM_W_EN_IN (mem_w_en_in),
        .ALUResIn    (alu_res_in),
        .STValIn     (st_val_in),
        .destIn      (dest_in),
        .WB_EN       (wb_en),
        .MEM_R_EN    (mem_r_en),
        .ALURes      (alu_res),
        .memData     (mem_data),
        .dest        (dest),
        .freeze      (freeze),
        .bus_err     (bus_err),
        .mem         (mem_if)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Transaction-level model: a mem op costs one IDLE cycle, ack_at BUSY cycles (or T when
    // no ack arrives in 1..T), then one DONE cycle. ack_at outside 1..T means no ack.
    task automatic run_op(input bit ld, input bit st, input bit wb, input logic [31:0] a,
                          input logic [31:0] sv, input logic [4:0] d, input int ack_at,
                          input logic [31:0] rd);
        bit          memop, mis, aborted, exp_rd, exp_wr;
        int          busy_n;
        logic [31:0] offs, exp_addr;
        memop    = ld | st;
        exp_rd   = ld;
        exp_wr   = st & ~ld;
        offs     = a - 32'(BASE);
        exp_addr = offs >> 2;
`ifdef MEM_ALIGN_CHECK_EN
        mis = memop && (a[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        @(posedge clk); #1;
        wb_en_in    = wb;
        mem_r_en_in = ld;
        mem_w_en_in = st;
        alu_res_in  = a;
        st_val_in   = sv;
        dest_in     = d;
        mem_if.mem_ack   = memop ? 1'b0 : 1'($urandom_range(0, 1));
        mem_if.mem_rdata = $urandom;
        @(negedge clk);
        if (!memop) begin
            check("alu_wb_en",   32'(wb_en),    32'(wb));
            check("alu_res",     alu_res,       a);
            check("alu_dest",    32'(dest),     32'(d));
            check("alu_freeze",  32'(freeze),   32'd0);
            check("alu_memdata", mem_data,      32'd0);
            check("alu_mem_rd",  32'(mem_if.mem_rd), 32'd0);
            return;
        end
        check("idle_freeze", 32'(freeze), 32'd1);
        check("idle_wb_en",  32'(wb_en),  32'd0);
        check("idle_mem_rd", 32'(mem_if.mem_rd), 32'd0);
        check("idle_mem_wr", 32'(mem_if.mem_wr), 32'd0);
        if (mis) begin
            busy_n  = 0;
            aborted = 1'b1;
        end else if (ack_at >= 1 && ack_at <= T) begin
            busy_n  = ack_at;
            aborted = 1'b0;
        end else begin
            busy_n  = T;
            aborted = 1'b1;
        end
        for (int c = 1; c <= busy_n; c++) begin
            @(posedge clk); #1;
            mem_if.mem_ack   = (c == ack_at);
            mem_if.mem_rdata = (c == ack_at) ? rd : $urandom;
            @(negedge clk);
            check("busy_freeze", 32'(freeze), 32'd1);
            check("busy_wb_en",  32'(wb_en),  32'd0);
            check("busy_mem_rd", 32'(mem_if.mem_rd), 32'(exp_rd));
            check("busy_mem_wr", 32'(mem_if.mem_wr), 32'(exp_wr));
            check("busy_addr",   mem_if.mem_addr, exp_addr);
            if (exp_wr) check("busy_wdata", mem_if.mem_wdata, sv);
        end
        @(posedge clk); #1;
        mem_if.mem_ack   = 1'($urandom_range(0, 1));
        mem_if.mem_rdata = $urandom;
        @(negedge clk);
        check("done_freeze",  32'(freeze),  32'd0);
        check("done_bus_err", 32'(bus_err), 32'(aborted));
        check("done_wb_en",   32'(wb_en),   aborted ? 32'd0 : 32'(wb));
        check("done_memdata", mem_data,     (aborted || !ld) ? 32'd0 : rd);
        check("done_mem_rd",  32'(mem_if.mem_rd), 32'd0);
        check("done_mem_wr",  32'(mem_if.mem_wr), 32'd0);
        check("done_r_en",    32'(mem_r_en), 32'(ld));
        check("done_dest",    32'(dest),     32'(d));
    endtask

    initial begin
        int          kind;
        logic [31:0] a;
        rst              = 1'b1;
        wb_en_in         = 1'b0;
        mem_r_en_in      = 1'b0;
        mem_w_en_in      = 1'b0;
        alu_res_in       = '0;
        st_val_in        = '0;
        dest_in          = '0;
        mem_if.mem_ack   = 1'b0;
        mem_if.mem_rdata = '0;

        repeat (2) @(negedge clk);
        check("rst_mem_rd",  32'(mem_if.mem_rd), 32'd0);
        check("rst_mem_wr",  32'(mem_if.mem_wr), 32'd0);
        check("rst_freeze",  32'(freeze),  32'd0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        check("rst_addr",    mem_if.mem_addr,  32'd0);
        check("rst_wdata",   mem_if.mem_wdata, 32'd0);
        check("rst_memdata", mem_data, 32'd0);
        rst = 1'b0;

        // Directed cases.
        run_op(0, 0, 1, 32'h55, 32'h0, 5'd3, 0, 32'h0);
        run_op(1, 0, 1, 32'd1028, 32'h0, 5'd7, 2, 32'hDEADBEEF);
        run_op(0, 1, 0, 32'd1032, 32'h1234, 5'd0, 1, 32'h0);
        run_op(1, 0, 1, 32'd1040, 32'h0, 5'd9, T + 1, 32'h0);
        run_op(1, 1, 1, 32'd1044, 32'hAAAA, 5'd11, T, 32'hCAFEF00D);
        run_op(1, 0, 1, 32'd1030, 32'h0, 5'd4, 1, 32'h13579BDF);

        // Reset in the middle of a BUSY wait.
        @(posedge clk); #1;
        wb_en_in = 1'b1; mem_r_en_in = 1'b1; mem_w_en_in = 1'b0;
        alu_res_in = 32'd1064; dest_in = 5'd2; mem_if.mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_mem_rd", 32'(mem_if.mem_rd), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_mem_rd",  32'(mem_if.mem_rd), 32'd0);
        check("mid_rst_freeze",  32'(freeze),  32'd0);
        check("mid_rst_bus_err", 32'(bus_err), 32'd0);
        check("mid_rst_addr",    mem_if.mem_addr, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mem_r_en_in = 1'b0;
        wb_en_in    = 1'b0;
        run_op(1, 0, 1, 32'd1072, 32'h0, 5'd6, 3, 32'h0BADC0DE);

        // Randomized transactions.
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 3);
            a    = 32'(BASE) + 32'(4 * $urandom_range(0, 1023));
            if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(1, 3));
            run_op(kind == 1 || kind == 3, kind == 2 || kind == 3, 1'($urandom_range(0, 1)),
                   a, $urandom, 5'($urandom_range(0, 31)), $urandom_range(1, T + 1), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
